// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream pattern generator.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } axis_gen_state_t;

  function automatic int BYTES_PER_BEAT(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_pattern_lane.sv
// Builds one beat word: byte lane i = base_byte + i (mod 256), lane 0 in bits [7:0].
module axis_pattern_lane
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [7:0]            base_byte,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int BYTES = BYTES_PER_BEAT(DATA_WIDTH);

  always_comb begin
    data = '0;
    for (int i = 0; i < BYTES; i++) begin
      data[8*i +: 8] = base_byte + 8'(i);
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream source emitting finite packets of an incrementing-byte pattern,
// with backpressure, pause gating of new beats and progress status.
module axis_pattern_gen
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [7:0]            seed,
  input  logic                  pause,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_count
);

  localparam int         BYTES     = BYTES_PER_BEAT(DATA_WIDTH);
  localparam logic [7:0] BASE_STEP = 8'(BYTES);

  axis_gen_state_t       state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [7:0]            base_q, base_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;

  // base_q/idx_q always describe the next beat still to be presented.
  logic [7:0]            cur_base;
  logic [LEN_WIDTH-1:0]  cur_idx;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [DATA_WIDTH-1:0] lane_data;
  logic                  hs;
  logic                  present;

  assign cur_base = (state_q == IDLE) ? seed    : base_q;
  assign cur_idx  = (state_q == IDLE) ? '0      : idx_q;
  assign cur_len  = (state_q == IDLE) ? pkt_len : len_q;
  assign hs       = valid_q & m_axis_ready;

  axis_pattern_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .base_byte (cur_base),
    .data      (lane_data)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    len_d   = len_q;
    base_d  = base_q;
    idx_d   = idx_q;
    present = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d = RUN;
          count_d = '0;
          len_d   = pkt_len;
          base_d  = seed;
          idx_d   = '0;
          present = !pause;
        end
      end
      RUN: begin
        if (hs) begin
          count_d = count_q + LEN_WIDTH'(1);
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
            last_d  = 1'b0;
          end
        end
        present = !pause && (hs ? !last_q : !valid_q);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (present) begin
      valid_d = 1'b1;
      data_d  = lane_data;
      last_d  = (cur_idx == (cur_len - LEN_WIDTH'(1)));
      base_d  = cur_base + BASE_STEP;
      idx_d   = cur_idx + LEN_WIDTH'(1);
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      len_q   <= len_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_last  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign beat_count   = count_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: spec-level packet model compared every cycle,
// directed literal scenarios and randomized ready/pause traffic.
module tb_axis_pattern_gen;

  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int BYTES = DW / 8;

  logic          axi_clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [7:0]    seed = '0;
  logic          pause = 1'b0;
  logic          m_axis_ready = 1'b0;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 axi_clk = ~axi_clk;

  axis_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .start        (start),
    .pkt_len      (pkt_len),
    .seed         (seed),
    .pause        (pause),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .busy         (busy),
    .done         (done),
    .beat_count   (beat_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: beat n byte i = (seed + n*BYTES + i) mod 256.
  function automatic logic [DW-1:0] pattern(input int s, input int n);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < BYTES; i++) w[8*i +: 8] = 8'((s + n * BYTES + i) % 256);
    return w;
  endfunction

  // Model: phase 0 idle, 1 sending, 2 done; m_n is the index of the beat to show next.
  int            m_ph = 0, m_n = 0, m_len = 0, m_seed = 0, e_cnt = 0;
  bit            e_valid = 0, e_last = 0, e_busy = 0, e_done = 0;
  logic [DW-1:0] e_data = '0;

  task show_beat();
    e_valid = 1;
    e_data  = pattern(m_seed, m_n);
    e_last  = (m_n == m_len - 1);
  endtask

  always @(posedge axi_clk) begin
    cyc++;
    if (axi_reset) begin
      m_ph = 0; m_n = 0; e_valid = 0; e_last = 0; e_data = '0; e_cnt = 0;
    end else begin
      case (m_ph)
        0: if (start && pkt_len != 0) begin
          m_ph = 1; m_len = int'(pkt_len); m_seed = int'(seed); m_n = 0; e_cnt = 0;
          if (!pause) show_beat();
        end
        1: begin
          if (e_valid && m_axis_ready) begin
            e_cnt++;
            if (e_last) m_ph = 2;
            else m_n++;
            e_valid = 0;
            e_last  = 0;
          end
          if (m_ph == 1 && !e_valid && !pause) show_beat();
        end
        default: m_ph = 0;
      endcase
    end
    e_busy = (m_ph == 1);
    e_done = (m_ph == 2);
  end

  logic [32:0]   cap_q[$];
  int            last_hs_edge = 0;
  bit            prev_v = 0, prev_r = 0, prev_rst = 1;
  logic [DW-1:0] prev_d = '0;
  bit            prev_l = 0;

  always @(negedge axi_clk) begin
    chk("valid", m_axis_valid, e_valid);
    chk("last", m_axis_last, e_last);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("beat_count", beat_count, e_cnt);
    if (e_valid) chk("data", m_axis_data, e_data);
    if (prev_v && !prev_r && !prev_rst) begin
      chk("hold_valid", m_axis_valid, 1'b1);
      chk("hold_data", m_axis_data, prev_d);
      chk("hold_last", m_axis_last, prev_l);
    end
    if (m_axis_valid && m_axis_ready && !axi_reset) begin
      cap_q.push_back({m_axis_last, m_axis_data});
      if (m_axis_last) last_hs_edge = cyc + 1;
    end
    prev_v = m_axis_valid; prev_r = m_axis_ready; prev_rst = axi_reset;
    prev_d = m_axis_data;  prev_l = m_axis_last;
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 1000) begin
      @(negedge axi_clk);
      if (done) break;
      k++;
    end
    tests++;
    if (k >= 1000) begin
      fails++;
      $display("FAIL %s: done never seen, got timeout expected done pulse", name);
    end
  endtask

  task automatic check_q(input string name, input logic [32:0] exp[$]);
    chk({name, "_beats"}, cap_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), cap_q[i], exp[i]);
  endtask

  initial begin
    logic [32:0] exp_q[$];
    bit v_seen, d_seen;
    int k, len;

    repeat (2) tick();
    @(negedge axi_clk);
    chk("rst_valid", m_axis_valid, 0);
    chk("rst_data", m_axis_data, 0);
    chk("rst_last", m_axis_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", beat_count, 0);
    tick(); axi_reset = 0;

    // basic packet
    tick(); cap_q.delete();
    start = 1; pkt_len = 3; seed = 8'h00; m_axis_ready = 1;
    tick(); start = 0;
    wait_done("basic_done");
    chk("basic_count", beat_count, 3);
    exp_q = '{{1'b0, 32'h03020100}, {1'b0, 32'h07060504}, {1'b1, 32'h0B0A0908}};
    check_q("basic", exp_q);

    // backpressure on beat 1
    tick(); cap_q.delete();
    start = 1; pkt_len = 3; seed = 8'h00; m_axis_ready = 1;
    tick(); start = 0;
    tick(); m_axis_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      chk("bp_valid", m_axis_valid, 1);
      chk("bp_data", m_axis_data, 32'h07060504);
      chk("bp_last", m_axis_last, 0);
      tick();
    end
    m_axis_ready = 1;
    wait_done("bp_done");
    check_q("bp", exp_q);

    // byte wrap, single beat
    tick(); cap_q.delete();
    start = 1; pkt_len = 1; seed = 8'hFE;
    tick(); start = 0;
    wait_done("wrap_done");
    exp_q = '{{1'b1, 32'h0100FFFE}};
    check_q("wrap", exp_q);

    // pause with pending beat 0, start during RUN ignored
    tick(); cap_q.delete();
    start = 1; pkt_len = 3; seed = 8'h00; m_axis_ready = 0; pause = 0;
    tick(); start = 0; pause = 1;
    tick(); m_axis_ready = 1;
    tick(); start = 1; pkt_len = 7; seed = 8'h55;
    @(negedge axi_clk); chk("pause_gap0", m_axis_valid, 0);
    tick(); start = 0;
    @(negedge axi_clk); chk("pause_gap1", m_axis_valid, 0);
    tick(); pause = 0;
    tick();
    @(negedge axi_clk);
    chk("pause_resume_valid", m_axis_valid, 1);
    chk("pause_resume_data", m_axis_data, 32'h07060504);
    wait_done("pause_done");
    exp_q = '{{1'b0, 32'h03020100}, {1'b0, 32'h07060504}, {1'b1, 32'h0B0A0908}};
    check_q("pause", exp_q);

    // zero length start
    tick(); start = 1; pkt_len = 0; seed = 8'h33;
    tick(); start = 0;
    v_seen = 0; d_seen = 0;
    repeat (6) begin
      @(negedge axi_clk);
      v_seen |= m_axis_valid; d_seen |= done | busy;
    end
    chk("len0_valid", v_seen, 0);
    chk("len0_done_busy", d_seen, 0);

    // reset after 2 of 5 beats
    tick(); cap_q.delete();
    start = 1; pkt_len = 5; seed = 8'h00; m_axis_ready = 1;
    tick(); start = 0;
    tick();
    tick(); axi_reset = 1; m_axis_ready = 0;
    tick(); axi_reset = 0;
    @(negedge axi_clk);
    chk("abort_valid", m_axis_valid, 0);
    chk("abort_data", m_axis_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", beat_count, 0);
    chk("abort_beats", cap_q.size(), 2);
    tick(); start = 1; pkt_len = 2; seed = 8'h10; m_axis_ready = 1;
    tick(); start = 0;
    @(negedge axi_clk);
    chk("restart_data", m_axis_data, 32'h13121110);
    wait_done("restart_done");

    // back-to-back with start held high
    tick(); start = 1; pkt_len = 2; seed = 8'h20;
    wait_done("b2b_done1");
    k = 0;
    while (k < 20) begin
      @(negedge axi_clk);
      if (m_axis_valid) break;
      k++;
    end
    chk("b2b_gap", cyc - last_hs_edge, 2);
    chk("b2b_count", beat_count, 0);
    tick(); start = 0;
    wait_done("b2b_done2");

    // randomized traffic
    for (int p = 0; p < 30; p++) begin
      tick(); cap_q.delete();
      len = (p == 0) ? 70 : $urandom_range(1, 9);
      start = 1; pkt_len = LW'(len); seed = 8'($urandom);
      m_axis_ready = 1'($urandom); pause = ($urandom_range(0, 3) == 0);
      k = 0;
      while (k < 1000) begin
        tick();
        start = 0;
        m_axis_ready = 1'($urandom); pause = ($urandom_range(0, 3) == 0);
        @(negedge axi_clk);
        if (done) break;
        k++;
      end
      tests++;
      if (k >= 1000) begin
        fails++;
        $display("FAIL rnd_timeout: packet %0d got no done expected done", p);
      end
      chk("rnd_beats", cap_q.size(), len);
      chk("rnd_count", beat_count, len);
    end
    pause = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
